hsi_serializer: RTL and testbench

- Transmit side of the gyro high-speed serial interface (HSI).
- Takes 32-bit words over a valid/ready handshake and serializes each one MSB-first onto HSDATA.
- Generates HSCK on a single system clock.
- Output pair drives an HSI tokenizer, directly or in loopback, sharing the same HSCK_POL convention.

---
 rtl/hsi_serializer.sv | 206 ++++++++++++++++++++
 tb/tb_hsi_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_serializer.sv
// hsi_serializer -- transmit side of the gyro high-speed serial interface.
//
// Takes 32-bit words over a valid/ready handshake and shifts each one out
// MSB-first on HSDATA. HSCK is generated from the system clock. Each bit
// cell is 2*CLK_DIV clocks long: phase A followed by phase B. HSDATA
// changes only at cell boundaries. The sampling edge of HSCK falls
// mid-cell, and its direction is selected by the polarity latched when the
// word was accepted. After the last cell, the block idles for GAP_CYCLES
// clocks before it takes the next word.
//
// Parameters:
//   CLK_DIV     system clocks per HSCK half-period (1..255)
//   GAP_CYCLES  idle clocks after each word (4..255)
//
// Ports:
//   clock      system clock; all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   HSCK_POL   1: receiver samples on HSCK rise; 0: on HSCK fall
//   data_in    word to transmit
//   valid_in   data_in is valid
//   ready_out  block accepts a word this cycle
//   HSCK       serial clock, idle 0, driven from a flop
//   HSDATA     serial data, idle 0, driven from a flop
//   busy       a word is being shifted or a gap is running
//   word_done  one-cycle pulse after the last bit cell of a word
//
// Optional feature: define HSI_TX_BUFFER_EN to add a one-word holding
// register. This lets the next word be accepted while the current word is
// still in flight, and sends the words back-to-back without an IDLE cycle.

module hsi_serializer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        HSCK_POL,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        HSCK,
  output logic        HSDATA,
  output logic        busy,
  output logic        word_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [31:0] shift_reg;
  logic        pol_q;      // polarity latched at accept, fixed for the word
  logic [7:0]  half_cnt;   // 0..CLK_DIV-1 within one phase
  logic        phase_b;    // 0 = phase A, 1 = phase B
  logic [4:0]  bit_cnt;    // current cell, 0..31
  logic [7:0]  gap_cnt;    // 0..GAP_CYCLES-1

  logic        accept;
  logic        gap_end;
  logic        start_word;
  logic [31:0] start_data;

  assign accept  = valid_in && ready_out;
  assign gap_end = (state == GAP) && (gap_cnt == GAP_LAST);
  assign busy    = (state != IDLE);

`ifdef HSI_TX_BUFFER_EN
  logic        hold_valid;
  logic [31:0] hold_data;

  assign ready_out = !hold_valid;

  // NOTE: every signal that is written in an always_comb block gets a
  // default assignment first. Without those defaults, a path that misses
  // the assignment infers a latch.
  always_comb begin
    start_word = 1'b0;
    start_data = data_in;
    if (state == IDLE) begin
      start_word = accept;
    end else if (gap_end) begin
      // At the end of the gap, a held word goes straight into SHIFT. If
      // nothing is held, a word accepted on this same edge goes straight
      // into SHIFT as well.
      if (hold_valid) begin
        start_word = 1'b1;
        start_data = hold_data;
      end else begin
        start_word = accept;
      end
    end
  end
`else
  assign ready_out = (state == IDLE);

  // Without the buffer, ready_out is only high in IDLE. That makes every
  // accept a start.
  always_comb begin
    start_word = accept;
    start_data = data_in;
  end
`endif

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments. Because of that, every read sees the value from before the
  // edge. Where two assignments hit the same register, the later one wins
  // (start_word overrides the GAP -> IDLE move).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      // NOTE: the datapath registers are reset along with the control
      // registers. This keeps HSCK/HSDATA and every counter at a known value
      // straight out of reset, and a word aborted by reset leaves nothing
      // behind.
      shift_reg <= '0;
      pol_q     <= 1'b0;
      half_cnt  <= '0;
      phase_b   <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      HSCK      <= 1'b0;
      HSDATA    <= 1'b0;
      word_done <= 1'b0;
`ifdef HSI_TX_BUFFER_EN
      hold_valid <= 1'b0;
      hold_data  <= '0;
`endif
    end else begin
      word_done <= 1'b0;

      unique case (state)
        IDLE: begin
          HSCK   <= 1'b0;
          HSDATA <= 1'b0;
        end

        SHIFT: begin
          // The line values are computed from the pre-edge cell position.
          // As a result, the first cell appears one edge after the accept.
          // POL=1 gives 0 in phase A and 1 in phase B; POL=0 inverts that.
          HSCK   <= (phase_b == pol_q);
          HSDATA <= shift_reg[31];
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            phase_b  <= !phase_b;
            if (phase_b) begin
              shift_reg <= {shift_reg[30:0], 1'b0};
              if (bit_cnt == 5'd31) begin
                state     <= GAP;
                gap_cnt   <= '0;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        GAP: begin
          HSCK   <= 1'b0;
          HSDATA <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          state  <= IDLE;
          HSCK   <= 1'b0;
          HSDATA <= 1'b0;
        end
      endcase

      if (start_word) begin
        state     <= SHIFT;
        shift_reg <= start_data;
        pol_q     <= HSCK_POL;
        half_cnt  <= '0;
        phase_b   <= 1'b0;
        bit_cnt   <= '0;
      end

`ifdef HSI_TX_BUFFER_EN
      // A word accepted mid-flight is parked here. The one case where it
      // starts directly instead is the gap-end edge with an empty buffer.
      if (gap_end && hold_valid) begin
        hold_valid <= 1'b0;
      end else if (accept && (state == SHIFT || (state == GAP && !gap_end))) begin
        hold_valid <= 1'b1;
        hold_data  <= data_in;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hsi_serializer.sv
// Testbench for hsi_serializer.
//
// The main instance runs with CLK_DIV=2 and GAP_CYCLES=8. A second instance
// runs with CLK_DIV=1 and GAP_CYCLES=4 and covers the single-cycle-phase
// corner.
//
// Stimulus pushes {word, polarity, accept edge} into a scoreboard queue at
// each accept. A separate monitor acts as the receiver: it watches HSCK for
// the sampling edge that matches the word's polarity, shifts in HSDATA at
// that edge, and on word_done compares the rebuilt word, the edge count and
// the timing against the queue entry.

module tb_hsi_serializer;

  localparam int D  = 2;
  localparam int G  = 8;
  localparam int D1 = 1;
  localparam int G1 = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        hsck_pol;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out, hsck, hsdata, busy, word_done;

  logic        d1_pol;
  logic [31:0] d1_data;
  logic        d1_valid;
  logic        d1_ready, d1_hsck, d1_hsdata, d1_busy, d1_done;

  hsi_serializer #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset_n(reset_n), .HSCK_POL(hsck_pol),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .HSCK(hsck), .HSDATA(hsdata), .busy(busy), .word_done(word_done)
  );

  hsi_serializer #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut1 (
    .clock(clock), .reset_n(reset_n), .HSCK_POL(d1_pol),
    .data_in(d1_data), .valid_in(d1_valid), .ready_out(d1_ready),
    .HSCK(d1_hsck), .HSDATA(d1_hsdata), .busy(d1_busy), .word_done(d1_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;   // number of rising edges so far
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        pol;
    int          acc;   // edge at which the word was accepted
  } exp_t;

  exp_t exp_q[$];

  // ---------------- receiver / scoreboard monitor ----------------
  initial begin : monitor
    logic        prev_hsck, prev_ready, pol_now, pend;
    logic [31:0] word;
    int          nbits, pend_acc;
    exp_t        e;
    prev_hsck = 1'b0; prev_ready = 1'b1; pend = 1'b0;
    word = '0; nbits = 0; pend_acc = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        nbits = 0; word = '0; pend = 1'b0;
        prev_hsck = 1'b0; prev_ready = ready_out;
      end else begin
        pol_now = (exp_q.size() > 0) ? exp_q[0].pol : 1'b1;
        // Sampling edge: a rise for POL=1, a fall for POL=0.
        if (hsck != prev_hsck && hsck == pol_now) begin
          word  = {word[30:0], hsdata};
          nbits++;
        end
        if (!busy) check("idle_lines_zero", {hsck, hsdata}, 2'b00);
        if (word_done) begin
          check("word_done_has_pending_word", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sampling_edge_count", nbits, 32);
            check("received_word", word, e.data);
            check("word_done_latency", cyc - e.acc, 64 * D);
            pend = 1'b1;
            pend_acc = e.acc;
          end
          nbits = 0; word = '0;
        end
        if (ready_out && !prev_ready && pend) begin
          // The edge that could take the next word, counted from the accept.
          check("ready_return_edge", cyc + 1 - pend_acc, 64 * D + G + 1);
          pend = 1'b0;
        end
        prev_hsck  = hsck;
        prev_ready = ready_out;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge. Presents the word, waits until it is accepted,
  // pushes the expectation, and returns at the negedge after the accept
  // edge. When keep is set, valid_in stays high.
  task automatic send(input logic [31:0] d, input logic p, input bit keep);
    int waited = 0;
    data_in  = d;
    hsck_pol = p;
    valid_in = 1'b1;
    while (!ready_out && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    if (!ready_out) begin
      timeout("ready_wait");
      valid_in = 1'b0;
    end else begin
      exp_q.push_back('{data: d, pol: p, acc: cyc + 1});
      @(negedge clock);
      if (!keep) valid_in = 1'b0;
      // Toggling the polarity input mid-word must have no effect.
      hsck_pol = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((busy || exp_q.size() > 0) && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    if (busy || exp_q.size() > 0) timeout("wait_idle");
    @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [63:0] exp_ck, exp_dt, act_ck, act_dt;
    int          done_j, done_cnt, rdy_j;
    logic [31:0] w;

    reset_n = 1'b0; valid_in = 1'b0; data_in = '0; hsck_pol = 1'b0;
    d1_valid = 1'b0; d1_data = '0; d1_pol = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ready", ready_out, 1);
    check("reset_lines", {hsck, hsdata, busy, word_done}, 4'b0000);
    check("reset_d1", {d1_ready, d1_hsck, d1_hsdata, d1_busy, d1_done}, 5'b10000);
    reset_n = 1'b1;
    @(negedge clock);

    // Single word, both polarities.
    send(32'hA5C30F96, 1'b1, 1'b0);
    wait_idle();
    send(32'hA5C30F96, 1'b0, 1'b0);
    wait_idle();
    check("idle_hsck_after_pol0", hsck, 0);

    // Words sent back-to-back with the receiver polarity matched.
    send(32'h00000000, 1'b1, 1'b0);
    send(32'hFFFFFFFF, 1'b1, 1'b0);
    send(32'h80000001, 1'b0, 1'b0);
    wait_idle();

    // valid_in held high throughout a word: it must not be captured twice.
    send(32'h12345678, 1'b1, 1'b1);
    send(32'h12345678, 1'b0, 1'b0);
    wait_idle();

    // Reset in bit cell 10. POL=0 and all-ones data keep both lines high there.
    send(32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (20 * D + 1) @(negedge clock);
    check("pre_reset_lines_high", {hsck, hsdata, busy}, 3'b111);
    #1 reset_n = 1'b0;
    #1;
    check("mid_word_reset_lines", {hsck, hsdata, busy, word_done}, 4'b0000);
    check("mid_word_reset_ready", ready_out, 1);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(32'h0000FFFF, 1'($urandom), 1'b0);
    wait_idle();

    // Random words, polarities and idle spacing.
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      send(w, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle();

    // CLK_DIV=1: the cell stream is checked clock by clock.
    check("d1_ready_idle", d1_ready, 1);
    d1_data = 32'h55555555; d1_pol = 1'b1; d1_valid = 1'b1;
    @(negedge clock);          // accept edge k has passed
    d1_valid = 1'b0;
    exp_ck = '0; exp_dt = '0; act_ck = '0; act_dt = '0;
    done_j = 0; done_cnt = 0; rdy_j = 0;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clock);        // after edge k+j
      // Phase = (j-1)%2 and cell = (j-1)/2; POL=1 gives HSCK = phase.
      exp_ck[64 - j] = 1'((j - 1) % 2);
      exp_dt[64 - j] = d1_data[31 - (j - 1) / 2];
      act_ck[64 - j] = d1_hsck;
      act_dt[64 - j] = d1_hsdata;
      if (d1_done) begin
        done_cnt++;
        if (done_j == 0) done_j = j;
      end
    end
    for (int j = 65; j <= 100 && rdy_j == 0; j++) begin
      @(negedge clock);
      if (d1_done) done_cnt++;
      if (d1_ready) rdy_j = j;
    end
    check("d1_hsck_stream", act_ck, exp_ck);
    check("d1_hsdata_stream", act_dt, exp_dt);
    check("d1_word_done_edge", done_j, 64 * D1);
    check("d1_word_done_pulses", done_cnt, 1);
    check("d1_ready_return_edge", rdy_j + 1, 64 * D1 + G1 + 1);
    check("d1_idle_lines", {d1_hsck, d1_hsdata, d1_busy}, 3'b000);

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
